// File: rtl/tcp_conn_ctrl.sv
// rtl/tcp_conn_ctrl.sv - passive-open TCP connection controller (LISTEN/SYN_RCVD/ESTABLISHED/LAST_ACK)
module tcp_conn_ctrl #(
  parameter logic [15:0] LOCAL_PORT = 16'd5000,
  parameter logic [31:0] ISN        = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT    = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_valid_i,
  input  logic        crc_ok_i,
  input  logic [15:0] seg_src_port_i,
  input  logic [15:0] seg_dst_port_i,
  input  logic [31:0] seg_seq_i,
  input  logic [31:0] seg_ack_i,
  input  logic [5:0]  seg_flags_i,
  input  logic [15:0] seg_data_len_i,
  output logic        tx_req_o,
  input  logic        tx_done_i,
  output logic [5:0]  tx_flags_o,
  output logic [31:0] tx_seq_o,
  output logic [31:0] tx_ack_o,
  output logic [15:0] tx_dst_port_o,
  output logic [2:0]  state_o,
  output logic        conn_est_o,
  output logic [15:0] drop_cnt_o
);

  typedef enum logic [2:0] {
    S_LISTEN   = 3'd0,
    S_SYN_RCVD = 3'd1,
    S_ESTAB    = 3'd2,
    S_LAST_ACK = 3'd3
  } state_t;

  localparam logic [5:0] F_ACK = 6'b010000;
  localparam logic [5:0] F_RST = 6'b000100;
  localparam logic [5:0] F_SYN = 6'b000010;
  localparam logic [5:0] F_FIN = 6'b000001;

  state_t      state_q, state_d;
  logic [15:0] remote_port_q, remote_port_d;
  logic [31:0] rcv_nxt_q, rcv_nxt_d;
  logic [31:0] snd_nxt_q, snd_nxt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tx_req_q, tx_req_d;
  logic [5:0]  tx_flags_q, tx_flags_d;
  logic [31:0] tx_seq_q, tx_seq_d;
  logic [31:0] tx_ack_q, tx_ack_d;
  logic [15:0] tx_port_q, tx_port_d;

  logic        f_ack, f_rst, f_syn, f_fin;
  logic        accept, busy, process;
  logic        timed_state;
  logic        issue;
  logic [5:0]  rsp_flags;
  logic [31:0] rsp_seq, rsp_ack;
  logic [15:0] rsp_port;
  logic [31:0] rcv_inorder;
  logic        unused_flags;

  assign f_ack = seg_flags_i[4];
  assign f_rst = seg_flags_i[2];
  assign f_syn = seg_flags_i[1];
  assign f_fin = seg_flags_i[0];
  // URG and PSH carry no meaning for connection control
  assign unused_flags = seg_flags_i[5] ^ seg_flags_i[3];

  // A segment belongs to us if checksum and port match; once a peer is latched only it may talk
  assign accept = seg_valid_i & crc_ok_i & (seg_dst_port_i == LOCAL_PORT) &
                  ((state_q == S_LISTEN) | (seg_src_port_i == remote_port_q));
  assign busy    = tx_req_q & ~tx_done_i;
  assign process = accept & ~busy;
  assign timed_state = (state_q == S_SYN_RCVD) | (state_q == S_LAST_ACK);
  // Next expected sequence after an in-order segment; a FIN consumes one sequence number
  assign rcv_inorder = rcv_nxt_q + {16'd0, seg_data_len_i} + {31'd0, f_fin};

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LISTEN;
      remote_port_q <= '0;
      rcv_nxt_q     <= '0;
      snd_nxt_q     <= '0;
      drop_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      tx_req_q      <= 1'b0;
      tx_flags_q    <= '0;
      tx_seq_q      <= '0;
      tx_ack_q      <= '0;
      tx_port_q     <= '0;
    end else begin
      state_q       <= state_d;
      remote_port_q <= remote_port_d;
      rcv_nxt_q     <= rcv_nxt_d;
      snd_nxt_q     <= snd_nxt_d;
      drop_cnt_q    <= drop_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      tx_req_q      <= tx_req_d;
      tx_flags_q    <= tx_flags_d;
      tx_seq_q      <= tx_seq_d;
      tx_ack_q      <= tx_ack_d;
      tx_port_q     <= tx_port_d;
    end
  end

  // Next-state: timeout first, then segment handling so a segment transition overrides it
  always_comb begin
    state_d       = state_q;
    remote_port_d = remote_port_q;
    rcv_nxt_d     = rcv_nxt_q;
    snd_nxt_d     = snd_nxt_q;
    drop_cnt_d    = drop_cnt_q;
    issue         = 1'b0;
    rsp_flags     = '0;
    rsp_seq       = '0;
    rsp_ack       = '0;
    rsp_port      = remote_port_q;

    if (timed_state && (tmo_cnt_q == TIMEOUT - 32'd1)) begin
      state_d = S_LISTEN;
    end

    if (accept && busy) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (process) begin
      case (state_q)
        S_LISTEN: begin
          if (f_syn && !f_ack && !f_rst) begin
            remote_port_d = seg_src_port_i;
            rcv_nxt_d     = seg_seq_i + 32'd1;
            snd_nxt_d     = ISN;
            issue         = 1'b1;
            rsp_flags     = F_SYN | F_ACK;
            rsp_seq       = ISN;
            rsp_ack       = seg_seq_i + 32'd1;
            rsp_port      = seg_src_port_i;
            state_d       = S_SYN_RCVD;
          end
        end
        S_SYN_RCVD: begin
          if (f_rst) begin
            state_d = S_LISTEN;
          end else if (f_ack && (seg_ack_i == ISN + 32'd1)) begin
            snd_nxt_d = ISN + 32'd1;
            state_d   = S_ESTAB;
          end else if (f_syn && (seg_seq_i + 32'd1 == rcv_nxt_q)) begin
            // Peer lost our SYN|ACK: send it again
            issue     = 1'b1;
            rsp_flags = F_SYN | F_ACK;
            rsp_seq   = ISN;
            rsp_ack   = rcv_nxt_q;
          end
        end
        S_ESTAB: begin
          if (f_rst) begin
            state_d = S_LISTEN;
          end else if (seg_seq_i == rcv_nxt_q) begin
            rcv_nxt_d = rcv_inorder;
            if (f_fin) begin
              issue     = 1'b1;
              rsp_flags = F_FIN | F_ACK;
              rsp_seq   = snd_nxt_q;
              rsp_ack   = rcv_inorder;
              state_d   = S_LAST_ACK;
            end else if (seg_data_len_i != 16'd0) begin
              issue     = 1'b1;
              rsp_flags = F_ACK;
              rsp_seq   = snd_nxt_q;
              rsp_ack   = rcv_inorder;
            end
          end else if ((seg_data_len_i != 16'd0) || f_fin) begin
            // Out-of-order data: re-announce what we still expect
            issue     = 1'b1;
            rsp_flags = F_ACK;
            rsp_seq   = snd_nxt_q;
            rsp_ack   = rcv_nxt_q;
          end
        end
        S_LAST_ACK: begin
          if (f_ack && (seg_ack_i == snd_nxt_q + 32'd1)) begin
            state_d = S_LISTEN;
          end
        end
        default: state_d = S_LISTEN;
      endcase
    end

    // Returning to LISTEN forgets the peer; an already issued response still completes
    if (state_d == S_LISTEN) begin
      remote_port_d = '0;
      rcv_nxt_d     = '0;
      snd_nxt_d     = '0;
    end

    if (state_d != state_q) tmo_cnt_d = '0;
    else if (timed_state)   tmo_cnt_d = tmo_cnt_q + 32'd1;
    else                    tmo_cnt_d = '0;

    tx_req_d   = tx_req_q;
    tx_flags_d = tx_flags_q;
    tx_seq_d   = tx_seq_q;
    tx_ack_d   = tx_ack_q;
    tx_port_d  = tx_port_q;
    if (issue) begin
      tx_req_d   = 1'b1;
      tx_flags_d = rsp_flags;
      tx_seq_d   = rsp_seq;
      tx_ack_d   = rsp_ack;
      tx_port_d  = rsp_port;
    end else if (tx_done_i) begin
      tx_req_d = 1'b0;
    end
  end

  // Outputs straight from registers so reset clears them without waiting for a clock
  always_comb begin
    tx_req_o      = tx_req_q;
    tx_flags_o    = tx_flags_q;
    tx_seq_o      = tx_seq_q;
    tx_ack_o      = tx_ack_q;
    tx_dst_port_o = tx_port_q;
    state_o       = state_q;
    conn_est_o    = (state_q == S_ESTAB);
    drop_cnt_o    = drop_cnt_q;
  end

endmodule

// File: tb/tb_tcp_conn_ctrl.sv
// tb/tb_tcp_conn_ctrl.sv - vector-table bench for tcp_conn_ctrl
module tb_tcp_conn_ctrl;

  localparam logic [31:0] TMO = 32'd16;
  localparam logic [15:0] LP  = 16'd5000;

  logic        clk = 1'b0;
  logic        rst;
  logic        seg_valid_i, crc_ok_i, tx_done_i;
  logic [15:0] seg_src_port_i, seg_dst_port_i, seg_data_len_i;
  logic [31:0] seg_seq_i, seg_ack_i;
  logic [5:0]  seg_flags_i;
  logic        tx_req_o, conn_est_o;
  logic [5:0]  tx_flags_o;
  logic [31:0] tx_seq_o, tx_ack_o;
  logic [15:0] tx_dst_port_o, drop_cnt_o;
  logic [2:0]  state_o;

  int tests = 0;
  int fails = 0;

  tcp_conn_ctrl #(.LOCAL_PORT(LP), .ISN(32'h0000_1000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .seg_valid_i(seg_valid_i), .crc_ok_i(crc_ok_i),
    .seg_src_port_i(seg_src_port_i), .seg_dst_port_i(seg_dst_port_i),
    .seg_seq_i(seg_seq_i), .seg_ack_i(seg_ack_i),
    .seg_flags_i(seg_flags_i), .seg_data_len_i(seg_data_len_i),
    .tx_req_o(tx_req_o), .tx_done_i(tx_done_i),
    .tx_flags_o(tx_flags_o), .tx_seq_o(tx_seq_o), .tx_ack_o(tx_ack_o),
    .tx_dst_port_o(tx_dst_port_o), .state_o(state_o),
    .conn_est_o(conn_est_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        val, crc;
    logic [15:0] src, dst;
    logic [31:0] seq, ack;
    logic [5:0]  fl;
    logic [15:0] len;
    logic        done;
    logic        ereq, chk;
    logic [5:0]  efl;
    logic [31:0] eseq, eack;
    logic [15:0] eport;
    logic [2:0]  est;
    logic [15:0] edrop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic val, logic crc, logic [15:0] src, logic [15:0] dst,
                              logic [31:0] seq, logic [31:0] ack, logic [5:0] fl,
                              logic [15:0] len, logic done, logic ereq, logic chk,
                              logic [5:0] efl, logic [31:0] eseq, logic [31:0] eack,
                              logic [15:0] eport, logic [2:0] est, logic [15:0] edrop);
    vec_t r;
    r.val = val; r.crc = crc; r.src = src; r.dst = dst; r.seq = seq; r.ack = ack;
    r.fl = fl; r.len = len; r.done = done; r.ereq = ereq; r.chk = chk; r.efl = efl;
    r.eseq = eseq; r.eack = eack; r.eport = eport; r.est = est; r.edrop = edrop;
    return r;
  endfunction

  function automatic vec_t dn(logic [2:0] est, logic [15:0] edrop);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, est, edrop);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    seg_valid_i = 0; crc_ok_i = 0; tx_done_i = 0;
    seg_src_port_i = 0; seg_dst_port_i = 0; seg_seq_i = 0; seg_ack_i = 0;
    seg_flags_i = 0; seg_data_len_i = 0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string n;
    seg_valid_i = v.val; crc_ok_i = v.crc; seg_src_port_i = v.src; seg_dst_port_i = v.dst;
    seg_seq_i = v.seq; seg_ack_i = v.ack; seg_flags_i = v.fl; seg_data_len_i = v.len;
    tx_done_i = v.done;
    @(posedge clk);
    #1;
    idle_inputs();
    n = $sformatf("v%0d", idx);
    chk({n, ".tx_req"}, {31'd0, tx_req_o}, {31'd0, v.ereq});
    chk({n, ".state"}, {29'd0, state_o}, {29'd0, v.est});
    chk({n, ".conn_est"}, {31'd0, conn_est_o}, {31'd0, (v.est == 3'd2)});
    chk({n, ".drop"}, {16'd0, drop_cnt_o}, {16'd0, v.edrop});
    if (v.chk) begin
      chk({n, ".flags"}, {26'd0, tx_flags_o}, {26'd0, v.efl});
      chk({n, ".seq"}, tx_seq_o, v.eseq);
      chk({n, ".ack"}, tx_ack_o, v.eack);
      chk({n, ".port"}, {16'd0, tx_dst_port_o}, {16'd0, v.eport});
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.tx_req", {31'd0, tx_req_o}, 32'd0);
    chk("rst.state", {29'd0, state_o}, 32'd0);
    chk("rst.drop", {16'd0, drop_cnt_o}, 32'd0);
    rst = 0;

    //           val crc src   dst  seq           ack           flags      len  dn req chk eflags     eseq      eack          eport st dr
    vecs.push_back(mk(1, 1, 1234, LP, 32'h100,      0,            6'b000010, 0, 0, 1, 1, 6'b010010, 32'h1000, 32'h101,      1234, 1, 0));
    vecs.push_back(dn(1, 0));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h101,      32'h1001,     6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h101,      32'h1001,     6'b010000, 8, 0, 1, 1, 6'b010000, 32'h1001, 32'h109,      1234, 2, 0));
    vecs.push_back(dn(2, 0));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h200,      32'h1001,     6'b010000, 4, 0, 1, 1, 6'b010000, 32'h1001, 32'h109,      1234, 2, 0));
    vecs.push_back(dn(2, 0));
    vecs.push_back(mk(1, 0, 1234, LP, 32'h109,      32'h1001,     6'b010001, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1, 1234, 80, 32'h109,      32'h1001,     6'b010001, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1, 999,  LP, 32'h109,      32'h1001,     6'b010001, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h109,      32'h1001,     6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h109,      32'h1001,     6'b010001, 0, 0, 1, 1, 6'b010001, 32'h1001, 32'h10A,      1234, 3, 0));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h10A,      32'h1002,     6'b010000, 0, 0, 1, 1, 6'b010001, 32'h1001, 32'h10A,      1234, 3, 1));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h10A,      32'h1002,     6'b010000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h300,      32'h1001,     6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1234, LP, 32'h300,      32'h1001,     6'b010010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4321, LP, 32'hFFFF_FFFF, 0,           6'b000010, 0, 0, 1, 1, 6'b010010, 32'h1000, 32'h0,        4321, 1, 1));
    vecs.push_back(mk(1, 1, 4321, LP, 32'hFFFF_FFFF, 0,           6'b000010, 0, 1, 1, 1, 6'b010010, 32'h1000, 32'h0,        4321, 1, 1));
    vecs.push_back(dn(1, 1));
    vecs.push_back(mk(1, 1, 4321, LP, 32'h0,        32'h1005,     6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 4321, LP, 32'h0,        32'h0,        6'b000100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4321, LP, 32'hFFFF_FFFB, 0,           6'b000010, 0, 0, 1, 1, 6'b010010, 32'h1000, 32'hFFFF_FFFC, 4321, 1, 1));
    vecs.push_back(dn(1, 1));
    vecs.push_back(mk(1, 1, 4321, LP, 32'hFFFF_FFFC, 32'h1001,    6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 1, 4321, LP, 32'hFFFF_FFFC, 32'h1001,    6'b010000, 8, 0, 1, 1, 6'b010000, 32'h1001, 32'h4,        4321, 2, 1));
    vecs.push_back(dn(2, 1));
    vecs.push_back(mk(1, 1, 4321, LP, 32'h4,        32'h0,        6'b000100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    foreach (vecs[i]) apply(vecs[i], i);

    // SYN_RCVD with no ACK: exactly TMO cycles in the state, then LISTEN
    apply(mk(1, 1, 777, LP, 32'h50, 0, 6'b000010, 0, 0, 1, 1, 6'b010010, 32'h1000, 32'h51, 777, 1, 1), 100);
    apply(dn(1, 1), 101);
    for (int k = 2; k < int'(TMO); k++) begin
      @(posedge clk);
      #1;
    end
    chk("tmo.before", {29'd0, state_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("tmo.after", {29'd0, state_o}, 32'd0);

    // Reset while ESTABLISHED with a response pending clears everything before any clock edge
    apply(mk(1, 1, 555, LP, 32'h10, 0, 6'b000010, 0, 0, 1, 1, 6'b010010, 32'h1000, 32'h11, 555, 1, 1), 110);
    apply(dn(1, 1), 111);
    apply(mk(1, 1, 555, LP, 32'h11, 32'h1001, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1), 112);
    apply(mk(1, 1, 555, LP, 32'h11, 32'h1001, 6'b010000, 3, 0, 1, 1, 6'b010000, 32'h1001, 32'h14, 555, 2, 1), 113);
    #2;
    rst = 1;
    #1;
    chk("arst.tx_req", {31'd0, tx_req_o}, 32'd0);
    chk("arst.flags", {26'd0, tx_flags_o}, 32'd0);
    chk("arst.seq", tx_seq_o, 32'd0);
    chk("arst.ack", tx_ack_o, 32'd0);
    chk("arst.port", {16'd0, tx_dst_port_o}, 32'd0);
    chk("arst.state", {29'd0, state_o}, 32'd0);
    chk("arst.conn_est", {31'd0, conn_est_o}, 32'd0);
    chk("arst.drop", {16'd0, drop_cnt_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tcp_conn_ctrl.md
TCP_CONN_CTRL -- requirements
Module: tcp_conn_ctrl

Interface
REQ-001 Parameter LOCAL_PORT, default 16'd5000: TCP port this block serves.
REQ-002 Parameter ISN, default 32'h0000_1000: initial send sequence number.
REQ-003 Parameter TIMEOUT, default 32'd1_000_000: cycles before SYN_RCVD/LAST_ACK abandon.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 seg_valid_i  in  1  one-cycle pulse; all seg_* and crc_ok_i stable this cycle.
REQ-007 crc_ok_i  in  1  checksum of current segment correct.
REQ-008 seg_src_port_i / seg_dst_port_i  in  16 each  segment ports.
REQ-009 seg_seq_i / seg_ack_i  in  32 each  segment sequence and acknowledge numbers.
REQ-010 seg_flags_i  in  6  [5]URG [4]ACK [3]PSH [2]RST [1]SYN [0]FIN.
REQ-011 seg_data_len_i  in  16  payload bytes (total length minus header length x4).
REQ-012 tx_req_o  out  1  response segment request, held until accepted.
REQ-013 tx_done_i  in  1  transmitter accepted the request this cycle.
REQ-014 tx_flags_o  out  6  response flags, same bit order as seg_flags_i.
REQ-015 tx_seq_o / tx_ack_o  out  32 each  response sequence / acknowledge numbers.
REQ-016 tx_dst_port_o  out  16  latched remote port.
REQ-017 state_o  out  3  LISTEN=0, SYN_RCVD=1, ESTABLISHED=2, LAST_ACK=3.
REQ-018 conn_est_o  out  1  high while state is ESTABLISHED.
REQ-019 drop_cnt_o  out  16  saturating count of segments dropped while busy.

Function
REQ-020 Segment accepted only if seg_valid_i & crc_ok_i & dst_port==LOCAL_PORT & (state LISTEN or src_port==latched remote port); others ignored, no counter change.
REQ-021 Busy = tx_req_o & ~tx_done_i; accepted segment while busy: no state/register change, drop_cnt_o += 1, saturating at 16'hFFFF.
REQ-022 tx_done_i and seg_valid_i in same cycle: not busy; segment processed; a new request, if any, keeps tx_req_o high next cycle.
REQ-023 Response issue: tx_req_o, tx_flags_o, tx_seq_o, tx_ack_o, tx_dst_port_o registered the cycle after seg_valid_i; held stable until tx_done_i; tx_req_o falls the cycle after tx_done_i unless REQ-022 applies.
REQ-024 LISTEN, SYN=1 & ACK=0 & RST=0: latch remote port; rcv_nxt=seq+1; snd_nxt=ISN; issue SYN|ACK (seq ISN, ack rcv_nxt); go SYN_RCVD.
REQ-025 LISTEN, any other segment: ignored, no response.
REQ-026 SYN_RCVD, ACK with seg_ack==ISN+1: snd_nxt=ISN+1; go ESTABLISHED; no response.
REQ-027 SYN_RCVD, RST: go LISTEN, no response; repeated SYN with seq+1==rcv_nxt: reissue SYN|ACK.
REQ-028 ESTABLISHED, RST: go LISTEN, no response.
REQ-029 ESTABLISHED, seg_seq==rcv_nxt: rcv_nxt += data_len (+1 if FIN); data_len>0 & FIN=0 -> issue ACK (seq snd_nxt, ack new rcv_nxt); data_len==0 & FIN=0 -> no response.
REQ-030 ESTABLISHED, in-order FIN: issue FIN|ACK (seq snd_nxt, ack new rcv_nxt); go LAST_ACK.
REQ-031 ESTABLISHED, seg_seq!=rcv_nxt & (data_len>0 or FIN): duplicate ACK with unchanged rcv_nxt; no state change.
REQ-032 LAST_ACK, ACK with seg_ack==snd_nxt+1: go LISTEN; other segments ignored.
REQ-033 Timeout counter clears on each entry to SYN_RCVD/LAST_ACK, increments each cycle there; reaching TIMEOUT-1 -> LISTEN next cycle, no response; segment transition in same cycle wins.
REQ-034 Sequence arithmetic modulo 2^32; wrap 32'hFFFF_FFFF+1 = 0 required.
REQ-035 Return to LISTEN clears remote port, rcv_nxt, snd_nxt; pending tx request still completes.

Reset
REQ-036 rst high: state LISTEN, all outputs, counters and internal registers 0, regardless of pending tx request; effective immediately, asynchronously.

Verification
REQ-037 LISTEN, SYN seq=32'h100, port 5000 -> next cycle tx_req=1, flags 6'b010010, seq 32'h1000, ack 32'h101, state 1.
REQ-038 Then ACK ack=32'h1001 -> state 2, conn_est_o=1; then 8-byte payload seq=32'h101 -> ACK, ack 32'h109.
REQ-039 ESTABLISHED, seq=32'h200 while rcv_nxt=32'h109 -> dup ACK ack 32'h109, state 2.
REQ-040 FIN seq=32'h109 -> FIN|ACK ack 32'h10A, state 3; ACK ack=32'h1002 -> state 0.
REQ-041 Segment while tx_req held, no tx_done -> drop_cnt_o=1, outputs unchanged; rcv_nxt near 32'hFFFF_FFFC plus 8 bytes -> ack 32'h4.
REQ-042 SYN_RCVD, no ACK for TIMEOUT cycles -> state 0; rst mid-ESTABLISHED -> all outputs 0 same cycle.
